// File: rtl/counter_pkg.sv
// Shared types and Gray-code helpers for the multi-mode counter.
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_BIN     = 2'b00,
    CNT_GRAY    = 2'b01,
    CNT_RING    = 2'b10,
    CNT_JOHNSON = 2'b11
  } count_type_e;

  localparam int unsigned MAX_W = 32;

  // Helpers work on zero-extended MAX_W vectors; only the low w bits are meaningful.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b,
                                                input int unsigned     w);
    logic [MAX_W-1:0] g;
    logic [MAX_W-1:0] s;
    g = '0;
    s = b >> 1;
    for (int unsigned i = 0; i < w; i++) begin
      g[i] = (i == w - 1) ? b[i] : (b[i] ^ s[i]);
    end
    return g;
  endfunction

  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g,
                                                input int unsigned     w);
    logic [MAX_W-1:0] b;
    b = '0;
    b[w-1] = g[w-1];
    for (int unsigned i = 1; i < w; i++) begin
      b[w-1-i] = g[w-1-i] ^ b[w-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-value logic for binary, Gray, ring and Johnson modes.
// Johnson stepping is only built when COUNTER_JOHNSON_EN is defined.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic [COUNT_WIDTH-1:0] i_count,
  input  logic                   i_dir,
  input  count_type_e            i_type,
  output logic [COUNT_WIDTH-1:0] o_next
);

  logic [COUNT_WIDTH-1:0] w_gray_bin;
  logic [COUNT_WIDTH-1:0] w_gray_step;

  assign w_gray_bin  = COUNT_WIDTH'(gray2bin(MAX_W'(i_count), COUNT_WIDTH));
  assign w_gray_step = i_dir ? (w_gray_bin + 1'b1) : (w_gray_bin - 1'b1);

  always_comb begin
    o_next = i_count;
    unique case (i_type)
      CNT_BIN:  o_next = i_dir ? (i_count + 1'b1) : (i_count - 1'b1);
      CNT_GRAY: o_next = COUNT_WIDTH'(bin2gray(MAX_W'(w_gray_step), COUNT_WIDTH));
      CNT_RING: o_next = i_dir ? {i_count[0], i_count[COUNT_WIDTH-1:1]}
                               : {i_count[COUNT_WIDTH-2:0], i_count[COUNT_WIDTH-1]};
`ifdef COUNTER_JOHNSON_EN
      CNT_JOHNSON: o_next = i_dir ? {~i_count[0], i_count[COUNT_WIDTH-1:1]}
                                  : {i_count[COUNT_WIDTH-2:0], ~i_count[COUNT_WIDTH-1]};
`else
      CNT_JOHNSON: o_next = i_count;
`endif
      default:  o_next = i_count;
    endcase
  end

endmodule

// File: rtl/counter_top.sv
// Multi-mode up/down counter: register plus reset > load > enable priority.
// Optional Johnson mode enabled by defining COUNTER_JOHNSON_EN.
module counter_top
  import counter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   count_dir,
  input  logic                   count_enable_,
  input  logic [1:0]             count_type,
  input  logic                   load_,
  input  logic [COUNT_WIDTH-1:0] load_val,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_next;

  counter_next #(.COUNT_WIDTH(COUNT_WIDTH)) u_next (
    .i_count (r_count),
    .i_dir   (count_dir),
    .i_type  (count_type_e'(count_type)),
    .o_next  (w_next)
  );

  // reset_ is active-high despite its name; load_ and count_enable_ are active-low.
  always_ff @(posedge clk) begin
    if (reset_) begin
      r_count <= '0;
    end else if (!load_) begin
      r_count <= load_val;
    end else if (!count_enable_) begin
      r_count <= w_next;
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_counter_top.sv
// Scoreboard bench for counter_top at COUNT_WIDTH=3.
module tb_counter_top;

  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         reset_ = 1'b1;
  logic         count_dir = 1'b1;
  logic         count_enable_ = 1'b1;
  logic [1:0]   count_type = 2'b00;
  logic         load_ = 1'b1;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count;

  typedef struct {
    logic [W-1:0] exp;
    string        name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  counter_top #(.COUNT_WIDTH(W)) dut (
    .clk           (clk),
    .reset_        (reset_),
    .count_dir     (count_dir),
    .count_enable_ (count_enable_),
    .count_type    (count_type),
    .load_         (load_),
    .load_val      (load_val),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic ld_n, input logic en_n,
                      input logic [1:0] typ, input logic dir,
                      input logic [W-1:0] val, input logic [W-1:0] exp,
                      input string name);
    exp_t e;
    reset_        = rst;
    load_         = ld_n;
    count_enable_ = en_n;
    count_type    = typ;
    count_dir     = dir;
    load_val      = val;
    @(posedge clk);
    #1;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (count !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b at %0t", e.name, count, e.exp, $time);
        end
      end
    end
  end

  initial begin : stim
    logic [W-1:0] jexp [6];
    int waited;
    #2;
    // Reset held 20 cycles while load and enable are also asserted
    for (int i = 0; i < 20; i++) step(1, 0, 0, 2'b00, 1, 3'b101, 3'b000, "reset_hold");
    step(0, 1, 0, 2'b00, 1, 3'b000, 3'b001, "post_reset_up1");
    step(0, 1, 0, 2'b00, 1, 3'b000, 3'b010, "post_reset_up2");

    // Gray up sequence from 101
    step(0, 0, 1, 2'b01, 1, 3'b101, 3'b101, "gray_load");
    step(0, 1, 0, 2'b01, 1, 3'b000, 3'b100, "gray_up");
    step(0, 1, 0, 2'b01, 1, 3'b000, 3'b000, "gray_up");
    step(0, 1, 0, 2'b01, 1, 3'b000, 3'b001, "gray_up");
    step(0, 1, 0, 2'b01, 1, 3'b000, 3'b011, "gray_up");
    step(0, 1, 0, 2'b01, 1, 3'b000, 3'b010, "gray_up");
    step(0, 1, 0, 2'b01, 1, 3'b000, 3'b110, "gray_up");
    step(0, 1, 0, 2'b01, 1, 3'b000, 3'b111, "gray_up");
    step(0, 1, 0, 2'b01, 1, 3'b000, 3'b101, "gray_up");
    step(0, 1, 0, 2'b01, 1, 3'b000, 3'b100, "gray_up");
    // Mode switch reuses register contents: binary 100 + 1
    step(0, 1, 0, 2'b00, 1, 3'b000, 3'b101, "type_switch_bin");
    // Gray down wrap: 000 decodes to 0, 0-1 = 7 -> gray 100
    step(0, 0, 1, 2'b01, 0, 3'b000, 3'b000, "gray_load0");
    step(0, 1, 0, 2'b01, 0, 3'b000, 3'b100, "gray_down_wrap");

    // Binary wrap both ways, load priority over enable, hold
    step(0, 0, 1, 2'b00, 0, 3'b000, 3'b000, "bin_load0");
    step(0, 1, 0, 2'b00, 0, 3'b000, 3'b111, "bin_down_wrap");
    step(0, 1, 0, 2'b00, 0, 3'b000, 3'b110, "bin_down");
    step(0, 0, 1, 2'b00, 1, 3'b111, 3'b111, "bin_load7");
    step(0, 1, 0, 2'b00, 1, 3'b000, 3'b000, "bin_up_wrap");
    step(0, 0, 0, 2'b00, 1, 3'b011, 3'b011, "load_beats_enable");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 2'b00, 1, 3'b000, 3'b011, "hold");

    // Ring rotate right then left
    step(0, 0, 1, 2'b10, 1, 3'b001, 3'b001, "ring_load");
    step(0, 1, 0, 2'b10, 1, 3'b000, 3'b100, "ring_right");
    step(0, 1, 0, 2'b10, 1, 3'b000, 3'b010, "ring_right");
    step(0, 1, 0, 2'b10, 1, 3'b000, 3'b001, "ring_right");
    step(0, 1, 0, 2'b10, 0, 3'b000, 3'b010, "ring_left");
    step(0, 1, 0, 2'b10, 0, 3'b000, 3'b100, "ring_left");
    step(0, 1, 0, 2'b10, 0, 3'b000, 3'b001, "ring_left");
    step(0, 0, 1, 2'b10, 1, 3'b000, 3'b000, "ring_load0");
    step(0, 1, 0, 2'b10, 1, 3'b000, 3'b000, "ring_zero_persist");

    // Johnson from reset
`ifdef COUNTER_JOHNSON_EN
    jexp = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
`else
    jexp = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
`endif
    step(1, 1, 1, 2'b11, 1, 3'b000, 3'b000, "johnson_reset");
    for (int i = 0; i < 6; i++) step(0, 1, 0, 2'b11, 1, 3'b000, jexp[i], "johnson_right");

    // Reset mid-count, then hold, then resume from zero
    step(0, 0, 1, 2'b00, 1, 3'b100, 3'b100, "mid_load");
    step(0, 1, 0, 2'b00, 1, 3'b000, 3'b101, "mid_up");
    step(1, 1, 0, 2'b00, 1, 3'b000, 3'b000, "mid_reset");
    for (int i = 0; i < 5; i++) step(0, 1, 1, 2'b00, 1, 3'b000, 3'b000, "post_reset_hold");
    step(0, 1, 0, 2'b00, 1, 3'b000, 3'b001, "resume_up");

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_top.md
COUNTER_TOP -- requirements
Module: counter_top

Interface
REQ-001 Parameter: COUNT_WIDTH, default 8, counter width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock; only clock.
REQ-003 Port: reset_  input  1  synchronous reset, ACTIVE-HIGH despite trailing underscore; sampled on rising clk.
REQ-004 Port: count_dir  input  1  direction; 1 = up/right, 0 = down/left.
REQ-005 Port: count_enable_  input  1  count enable, active-low.
REQ-006 Port: count_type  input  2  00 binary, 01 Gray, 10 ring, 11 Johnson.
REQ-007 Port: load_  input  1  synchronous load strobe, active-low.
REQ-008 Port: load_val  input  COUNT_WIDTH  value loaded when load_=0.
REQ-009 Port: count  output  COUNT_WIDTH  registered counter value, driven directly from flops.

Function
REQ-010 Priority per rising clk: reset_=1 > load_=0 > count_enable_=0 > hold.
REQ-011 Load: count <= load_val on the same edge; visible 1 cycle after strobe sampled; load_val stored verbatim regardless of count_type.
REQ-012 Hold: count_enable_=1 and load_=1 -> count unchanged.
REQ-013 Binary (00): dir=1 -> count+1, dir=0 -> count-1, modulo 2^COUNT_WIDTH (111..1 -> 0 up, 0 -> 111..1 down).
REQ-014 Gray (01): next = bin2gray(gray2bin(count) +/- 1), modulo 2^COUNT_WIDTH; wraps same as binary in decoded domain.
REQ-015 bin2gray: g[i] = b[i]^b[i+1] for i < W-1, g[W-1] = b[W-1]; gray2bin: b[W-1] = g[W-1], b[i] = g[i]^b[i+1].
REQ-016 Ring (10): dir=1 -> rotate right {count[0], count[W-1:1]}; dir=0 -> rotate left {count[W-2:0], count[W-1]}; all-zero/all-one values persist (no self-correction).
REQ-017 Johnson (11): dir=1 -> {~count[0], count[W-1:1]}; dir=0 -> {count[W-2:0], ~count[W-1]}; period 2*W from 0.
REQ-018 count_type or count_dir change: next step applies new rule to current register contents; no re-encoding.
REQ-019 Load and enable both asserted: load wins, no count step that cycle.

Reset
REQ-020 reset_=1 at rising clk -> count = 0 next edge, overriding load and enable.
REQ-021 Reset mid-count -> count 0; counting resumes from 0 on first edge with reset_=0 and count_enable_=0.
REQ-022 No asynchronous reset path; count undefined before first reset edge.

Configuration
REQ-023 Macro COUNTER_JOHNSON_EN defined -> Johnson mode per REQ-017.
REQ-024 Macro undefined -> count_type=11 holds count (no Johnson logic synthesized); other modes unaffected.

Structure
REQ-025 Package counter_pkg: enum count_type_e (CNT_BIN=2'b00, CNT_GRAY=2'b01, CNT_RING=2'b10, CNT_JOHNSON=2'b11), bin2gray/gray2bin functions parameterized by width.
REQ-026 One sub-module counter_next: combinational next-value logic (count, dir, type -> next); counter_top holds register and priority mux.

Verification (COUNT_WIDTH=3)
REQ-027 Reset 20 cycles with load_=0, count_enable_=0 -> count 000 throughout; release -> count steps from 000.
REQ-028 Gray up: load 101, then enable -> 100, 000, 001, 011, 010, 110, 111, 101, 100.
REQ-029 Binary down from load 000 -> 111, 110; binary up from 111 -> 000; load_=0 with count_enable_=0 -> load value, no step.
REQ-030 Ring: load 001, dir=1 -> 100, 010, 001; dir=0 from 001 -> 010, 100, 001.
REQ-031 Johnson (macro defined): from reset, dir=1 -> 100, 110, 111, 011, 001, 000; macro undefined -> count holds 000.
REQ-032 Reset asserted mid-count at value 101 -> 000 next edge; count_enable_=1 -> value held for 5 cycles.
